aq_prio_arb: RTL

- Parametrised matrix-based LRU arbiter for the LSU request queues; successor to the plain matrix priority selector.
- Adds a two-class request scheme (urgent/normal), multi-beat grant locking, a valid/ready grant handshake and optional starvation promotion.
- Sits between NUM queue entries or ports and a single shared downstream resource (e.g. a bus request slot or a cache pipe).

---
 rtl/aq_prio_pkg.sv | 24 ++
 rtl/aq_prio_matrix.sv | 39 +++
 rtl/aq_prio_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/aq_prio_pkg.sv
// Shared constants and helpers for the aq_prio matrix LRU arbiter.
// Holds the default sizing, the one-hot encoder and the matrix reset pattern.
package aq_prio_pkg;

  localparam int NUM_DEF       = 4;
  localparam int CNT_W_DEF     = 4;
  localparam int STARVE_TH_DEF = 12;
  localparam int MAX_NUM       = 64;

  function automatic int unsigned oh2idx(input logic [MAX_NUM-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_NUM; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  // prio[i][j]=1 means j beats i; at reset lower indices beat higher ones.
  function automatic logic prio_rst_bit(input int i, input int j);
    return (j < i);
  endfunction

endpackage

// File: rtl/aq_prio_matrix.sv
// NUM x NUM LRU priority matrix: combinational one-hot pick from a candidate vector.
// Zero-latency select; the winner drops to lowest priority on the update strobe.
import aq_prio_pkg::*;

module aq_prio_matrix #(
  parameter int NUM = NUM_DEF
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic [NUM-1:0] cand,
  input  logic           upd,
  input  logic [NUM-1:0] win_oh,
  output logic [NUM-1:0] sel_oh
);

  logic [NUM-1:0][NUM-1:0] prio;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM; i++) begin
        for (int j = 0; j < NUM; j++) begin
          prio[i][j] <= prio_rst_bit(i, j);
        end
      end
    end else if (upd) begin
      for (int i = 0; i < NUM; i++) begin
        prio[i] <= win_oh[i] ? ~win_oh : (prio[i] & ~win_oh);
      end
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM; i++) begin
      sel_oh[i] = cand[i] & ~|(cand & prio[i]);
    end
  end

endmodule

// File: rtl/aq_prio_arb.sv
// Two-class LRU arbiter with multi-beat locking; zero-latency grant, held while gnt_rdy=0.
// AQ_PRIO_STARVE_EN adds per-requestor starvation counters that promote waiting normals.
import aq_prio_pkg::*;

module aq_prio_arb #(
  parameter int NUM       = NUM_DEF,
  parameter int IDX_W     = $clog2(NUM),
  parameter int CNT_W     = CNT_W_DEF,
  parameter int STARVE_TH = STARVE_TH_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [NUM-1:0]   req_vld,
  input  logic [NUM-1:0]   req_urg,
  input  logic [NUM-1:0]   req_last,
  input  logic             gnt_rdy,
  output logic             gnt_vld,
  output logic [NUM-1:0]   gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             locked
);

  if (NUM < 2 || NUM > MAX_NUM) begin : g_bad_num
    $error("aq_prio_arb: NUM out of range");
  end
  if (STARVE_TH >= (1 << CNT_W)) begin : g_bad_th
    $error("aq_prio_arb: STARVE_TH does not fit in CNT_W");
  end

  logic [NUM-1:0]   eff_urg;
  logic [NUM-1:0]   cand;
  logic [NUM-1:0]   arb_oh;
  logic [NUM-1:0]   owner_oh;
  logic [IDX_W-1:0] owner;
  logic             accept;
  logic             last_beat;
  logic             upd;

`ifdef AQ_PRIO_STARVE_EN
  logic [NUM-1:0][CNT_W-1:0] cnt;
  logic [NUM-1:0]            starve;

  always_comb begin
    starve = '0;
    for (int i = 0; i < NUM; i++) begin
      starve[i] = (cnt[i] >= CNT_W'(STARVE_TH));
    end
  end

  // An accepted beat clears the counter even if it just hit the threshold.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (!req_vld[i] || (accept && gnt_oh[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] != {CNT_W{1'b1}}) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign eff_urg = req_vld & (req_urg | starve);
`else
  assign eff_urg = req_vld & req_urg;
`endif

  assign cand = (|eff_urg) ? eff_urg : req_vld;

  aq_prio_matrix #(.NUM(NUM)) u_matrix (
    .clk    (clk),
    .rst_b  (rst_b),
    .cand   (cand),
    .upd    (upd),
    .win_oh (gnt_oh),
    .sel_oh (arb_oh)
  );

  // While locked only the owner may be granted; class and matrix are bypassed.
  assign owner_oh  = NUM'(1) << owner;
  assign gnt_oh    = locked ? (owner_oh & req_vld) : arb_oh;
  assign gnt_vld   = |gnt_oh;
  assign gnt_idx   = IDX_W'(oh2idx(MAX_NUM'(gnt_oh)));
  assign accept    = gnt_vld & gnt_rdy;
  assign last_beat = |(gnt_oh & req_last);
  assign upd       = accept & last_beat;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      locked <= 1'b0;
      owner  <= '0;
    end else if (accept) begin
      if (last_beat) begin
        locked <= 1'b0;
      end else begin
        locked <= 1'b1;
        owner  <= gnt_idx;
      end
    end
  end

  ast_owner_held: assert property (@(posedge clk) disable iff (!rst_b)
    locked |-> req_vld[owner]);

endmodule
